// File: rtl/serdes_pkg.sv
// Shared types and constants for the SerDes transmit scheduler.
// Holds the scheduler state encoding, the fixed fill patterns and a width helper.
package serdes_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } sched_state_t;

  localparam logic [31:0] TRAIN_PAT = 32'hAAAA_AAAA;
  localparam logic [31:0] IDLE_PAT  = 32'h5555_5555;

  // Counter/index width that stays at least 1 bit for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serdes_tx_sched_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping around; gnt_vld is low when nothing is requesting.
module rr_arbiter
  import serdes_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               gnt_vld,
  output logic [IDX_W-1:0]   gnt_idx
);

  // Offsets are walked from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req[j] && (j == (int'(ptr) + i) % NUM_REQ)) begin
          gnt_vld = 1'b1;
          gnt_idx = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/serdes_tx_sched.sv
// Transmit scheduler ahead of the serializer: link training preamble, then
// round-robin sharing of one word slot per SER_CYCLES clocks, idle fill when unclaimed.
//
// Handshake: a word moves from requester k when req_valid[k] && req_ready[k] on a
// rising edge; req_ready is combinational, at most one-hot, and only high in the
// RUN slot_end cycle; requesters must hold req_valid/req_data stable until accepted.
module serdes_tx_sched
  import serdes_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 32,
  parameter int SER_CYCLES  = 32,
  parameter int TRAIN_WORDS = 8,
  localparam int IDX_W = idx_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      link_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         ser_data,
  output logic                      ser_load,
  output logic [IDX_W-1:0]          grant_id,
  output logic [1:0]                state,
  output logic                      train_done
);

  localparam int SC_W = idx_width(SER_CYCLES);
  localparam int TC_W = idx_width(TRAIN_WORDS);
  localparam logic [SC_W-1:0]  SLOT_LAST  = SC_W'(SER_CYCLES - 1);
  localparam logic [TC_W-1:0]  TRAIN_LAST = TC_W'(TRAIN_WORDS - 1);
  localparam logic [IDX_W-1:0] PTR_LAST   = IDX_W'(NUM_REQ - 1);

  sched_state_t     state_q, state_d;
  logic [SC_W-1:0]  slot_cnt;
  logic [TC_W-1:0]  train_cnt;
  logic [IDX_W-1:0] rr_ptr;
  logic             slot_end;
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;

  // link_en is part of slot_end so a falling link_en suppresses load and grant together.
  assign slot_end = (slot_cnt == SLOT_LAST) && link_en && (state_q != ST_OFF);
  assign state    = state_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_OFF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      ST_OFF: begin
        if (link_en) state_d = ST_TRAIN;
      end
      ST_TRAIN: begin
        if (!link_en)                                state_d = ST_OFF;
        else if (slot_end && train_cnt == TRAIN_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!link_en)                state_d = ST_OFF;
        else if (slot_end && gnt_vld) req_ready[gnt_idx] = 1'b1;
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt   <= SLOT_LAST;
      train_cnt  <= '0;
      rr_ptr     <= '0;
      ser_data   <= '0;
      ser_load   <= 1'b0;
      grant_id   <= '0;
      train_done <= 1'b0;
    end else begin
      ser_load <= slot_end;

      // Parking the slot counter at its last value makes TRAIN open with a slot end.
      if (!link_en || state_q == ST_OFF) begin
        slot_cnt  <= SLOT_LAST;
        train_cnt <= '0;
      end else begin
        slot_cnt <= (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
      end

      if (!link_en) begin
        ser_data   <= '0;
        grant_id   <= '0;
        train_done <= 1'b0;
      end else if (state_q == ST_OFF) begin
        train_done <= 1'b0;
      end else if (slot_end) begin
        if (state_q == ST_TRAIN) begin
          ser_data  <= DATA_W'(TRAIN_PAT);
          grant_id  <= '0;
          train_cnt <= train_cnt + 1'b1;
          if (train_cnt == TRAIN_LAST) train_done <= 1'b1;
        end else if (gnt_vld) begin
          ser_data <= req_data[gnt_idx*DATA_W +: DATA_W];
          grant_id <= gnt_idx;
          rr_ptr   <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
        end else begin
          ser_data <= DATA_W'(IDLE_PAT);
          grant_id <= '0;
        end
      end
    end
  end

endmodule
